// File: rtl/snn_inference_sequencer.sv
// Sequences one inference of the 8-input / 2-output SNN core: captures the input,
// clears the core, steps it TSTEPS times and reports per-neuron spike counts and the winner.
module snn_inference_sequencer #(
  parameter int unsigned TSTEPS = 16,
  parameter int unsigned CNT_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       value_in,
  input  logic [1:0]       snn_spikes,
  output logic             snn_reset,
  output logic             snn_en,
  output logic [7:0]       snn_value,
  output logic             busy,
  output logic             done,
  output logic             result_valid,
  output logic [CNT_W-1:0] count0,
  output logic [CNT_W-1:0] count1,
  output logic             winner,
  output logic             tie
);

  localparam int unsigned STEP_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [7:0]         value_q, value_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [CNT_W-1:0]   count0_q, count0_d;
  logic [CNT_W-1:0]   count1_q, count1_d;
  logic               winner_q, winner_d;
  logic               tie_q, tie_d;
  logic               valid_q, valid_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      value_q  <= '0;
      step_q   <= '0;
      count0_q <= '0;
      count1_q <= '0;
      winner_q <= 1'b0;
      tie_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      step_q   <= step_d;
      count0_q <= count0_d;
      count1_q <= count1_d;
      winner_q <= winner_d;
      tie_q    <= tie_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    step_d   = step_q;
    count0_d = count0_q;
    count1_d = count1_q;
    winner_d = winner_q;
    tie_d    = tie_q;
    valid_d  = valid_q;
    case (state_q)
      IDLE: begin
        // abort outranks a simultaneous start
        if (start && !abort) begin
          state_d  = CLEAR;
          value_d  = value_in;
          count0_d = '0;
          count1_d = '0;
          winner_d = 1'b0;
          tie_d    = 1'b0;
          valid_d  = 1'b0;
        end
      end
      CLEAR: begin
        if (abort) begin
          state_d  = IDLE;
          count0_d = '0;
          count1_d = '0;
          valid_d  = 1'b0;
        end else begin
          step_d  = STEP_W'(TSTEPS - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d  = IDLE;
          count0_d = '0;
          count1_d = '0;
          valid_d  = 1'b0;
        end else begin
          // saturating per-neuron spike accumulation, including the final step
          if (snn_spikes[0] && (count0_q != CNT_MAX)) count0_d = count0_q + CNT_W'(1);
          if (snn_spikes[1] && (count1_q != CNT_MAX)) count1_d = count1_q + CNT_W'(1);
          step_d = step_q - STEP_W'(1);
          if (step_q == '0) begin
            state_d  = DONE;
            winner_d = (count1_d > count0_d);
            tie_d    = (count1_d == count0_d);
            valid_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign snn_reset    = reset | (state_q == CLEAR);
  assign snn_en       = (state_q == RUN);
  assign busy         = (state_q == CLEAR) || (state_q == RUN);
  assign done         = (state_q == DONE);
  assign snn_value    = value_q;
  assign result_valid = valid_q;
  assign count0       = count0_q;
  assign count1       = count1_q;
  assign winner       = winner_q;
  assign tie          = tie_q;

endmodule
